// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous clear and parallel load.
// It has an optional saturation mode, a sticky wrap/saturation flag and a combinational terminal count.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic at_top;
    logic at_bottom;

    assign at_top    = (counter == MAXV);
    assign at_bottom = (counter == '0);

    always_comb begin
        tc = 1'b0;
        if (en && !clr && !load) begin
            tc = up_dn ? at_top : at_bottom;
        end
    end

    // Steps are only taken away from the range ends, so the +/-1 never overflows WIDTH bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            counter <= '0;
            ovf     <= 1'b0;
        end else if (load) begin
            counter <= (load_val > MAXV) ? MAXV : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (at_top) begin
                    counter <= (SATURATE != 0) ? MAXV : '0;
                    ovf     <= 1'b1;
                end else begin
                    counter <= counter + ONE;
                end
            end else begin
                if (at_bottom) begin
                    counter <= (SATURATE != 0) ? '0 : MAXV;
                    ovf     <= 1'b1;
                end else begin
                    counter <= counter - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter with three instances: mod-10 wrap, mod-10 saturate, and default mod-16.
// Fixed vectors, hand sequences and random stimulus are all compared against an integer reference model.
module tb_updown_mod_counter;

    logic       clk = 1'b1;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;

    logic [3:0] cnt [3];
    logic       tcv [3];
    logic       ovf [3];

    int checks = 0;
    int failures = 0;

    int mods [3] = '{10, 10, 16};
    int sats [3] = '{0, 1, 0};
    int mc [3];
    int mo [3];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap10 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .counter(cnt[0]), .tc(tcv[0]), .ovf(ovf[0]));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat10 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .counter(cnt[1]), .tc(tcv[1]), .ovf(ovf[1]));

    updown_mod_counter u_def16 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .counter(cnt[2]), .tc(tcv[2]), .ovf(ovf[2]));

    typedef struct {
        logic       c;
        logic       l;
        logic [3:0] v;
        logic       e;
        logic       u;
        int         exp_cnt;
        int         exp_ovf;
        int         exp_tc;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] v, input logic e, input logic u);
        clr = c; load = l; load_val = v; en = e; up_dn = u;
    endtask

    function automatic int model_tc(input int i);
        if (!en || clr || load) return 0;
        return (mc[i] == (up_dn ? mods[i] - 1 : 0)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            mo[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int n;
            if (clr) begin
                mc[i] = 0;
                mo[i] = 0;
            end else if (load) begin
                mc[i] = (int'(load_val) > mods[i] - 1) ? mods[i] - 1 : int'(load_val);
            end else if (en) begin
                n = mc[i] + (up_dn ? 1 : -1);
                if (n < 0 || n >= mods[i]) begin
                    mo[i] = 1;
                    if (sats[i] == 0) mc[i] = (n + mods[i]) % mods[i];
                end else begin
                    mc[i] = n;
                end
            end
        end
    endtask

    logic tc_seen [3];

    // Called 1 ns after a rising edge with inputs already driven.
    task automatic step();
        #2;
        for (int i = 0; i < 3; i++) begin
            tc_seen[i] = tcv[i];
            check($sformatf("tc[%0d]", i), 32'(tcv[i]), 32'(model_tc(i)));
        end
        @(posedge clk);
        #1;
        model_edge();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("counter[%0d]", i), 32'(cnt[i]), 32'(mc[i]));
            check($sformatf("ovf[%0d]", i), 32'(ovf[i]), 32'(mo[i]));
        end
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #11;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_counter[%0d]", i), 32'(cnt[i]), 32'd0);
            check($sformatf("reset_ovf[%0d]", i), 32'(ovf[i]), 32'd0);
        end
        #4 rst = 1'b0;

        // Mod-10 wrap instance: count-up wrap, load and count-down, priority, load clamp.
        for (int k = 1; k <= 12; k++)
            vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, k % 10, (k >= 10) ? 1 : 0, (k == 10) ? 1 : 0});
        vecs.push_back('{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 0, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 3, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 0, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 9, 1, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8, 1, 0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 8, 1, 0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 9, 1, 0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 9, 1, 0});
        vecs.push_back('{1'b1, 1'b1, 4'd12, 1'b1, 1'b1, 0, 0, 0});

        foreach (vecs[j]) begin
            drive(vecs[j].c, vecs[j].l, vecs[j].v, vecs[j].e, vecs[j].u);
            step();
            check($sformatf("vec%0d_counter", j), 32'(cnt[0]), 32'(vecs[j].exp_cnt));
            check($sformatf("vec%0d_ovf", j), 32'(ovf[0]), 32'(vecs[j].exp_ovf));
            check($sformatf("vec%0d_tc", j), 32'(tc_seen[0]), 32'(vecs[j].exp_tc));
        end

        // Saturating instance: load 8, then up x4 holds at 9, then one step down.
        drive(1'b0, 1'b1, 4'd8, 1'b0, 1'b1); step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); step();
            check("sat_hold_counter", 32'(cnt[1]), 32'd9);
            check("sat_hold_ovf", 32'(ovf[1]), (k >= 1) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0); step();
        check("sat_down_counter", 32'(cnt[1]), 32'd8);

        // Default mod-16 instance: wrap both directions.
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0); step();
        drive(1'b0, 1'b1, 4'd15, 1'b0, 1'b0); step();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); step();
        check("m16_up_wrap_counter", 32'(cnt[2]), 32'd0);
        check("m16_up_wrap_ovf", 32'(ovf[2]), 32'd1);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0); step();
        check("m16_down_wrap_counter", 32'(cnt[2]), 32'd15);

        // Asynchronous reset between edges at counter 6 with ovf set.
        drive(1'b0, 1'b1, 4'd6, 1'b0, 1'b0); step();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_counter", 32'(cnt[0]), 32'd0);
        check("async_rst_ovf", 32'(ovf[0]), 32'd0);
        rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); step();
        check("resume_counter", 32'(cnt[0]), 32'd1);

        // Reset held across edges dominates clr/load/en.
        drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_hold_counter[%0d]", i), 32'(cnt[i]), 32'd0);
            check($sformatf("rst_hold_ovf[%0d]", i), 32'(ovf[i]), 32'd0);
        end
        rst = 1'b0;
        model_reset();

        // Random stimulus against the model, with occasional mid-cycle reset pulses.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(39) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
                model_reset();
            end
            drive($urandom_range(15) == 0, $urandom_range(7) == 0, 4'($urandom_range(15)),
                  $urandom_range(3) != 0, $urandom_range(1) == 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
